// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types and constants for the FPU issue controller and its attached units.
package fpu_pkg;

    typedef enum logic [1:0] {
        FOP_ADD  = 2'd0,
        FOP_MUL  = 2'd1,
        FOP_DIV  = 2'd2,
        FOP_SQRT = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } fpu_state_e;

    // Unit protocol: one result lane per unit, rd valid only in the done cycle.
    localparam int FU_DATA_W = 32;

    function automatic int op_w(input int n_units);
        return (n_units > 1) ? $clog2(n_units) : 1;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Bundle of the execute-stage request, FPU unit and writeback handshakes.
interface fpu_issue_ctrl_if
    import fpu_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TAG_W   = 5
);
    localparam int OP_W = op_w(N_UNITS);

    logic                           req_valid;
    logic                           req_ready;
    logic [OP_W-1:0]                req_op;
    logic [31:0]                    req_rs1;
    logic [31:0]                    req_rs2;
    logic [TAG_W-1:0]               req_tag;

    logic [N_UNITS-1:0]             fu_order;
    logic [N_UNITS-1:0]             fu_accepted;
    logic [N_UNITS-1:0]             fu_done;
    logic [FU_DATA_W*N_UNITS-1:0]   fu_rd;
    logic [31:0]                    fu_rs1;
    logic [31:0]                    fu_rs2;

    logic                           wb_valid;
    logic                           wb_ready;
    logic [31:0]                    wb_data;
    logic [TAG_W-1:0]               wb_tag;
    logic                           wb_err;

    modport master (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag,
        input  fu_accepted, fu_done, fu_rd, wb_ready,
        output req_ready, fu_order, fu_rs1, fu_rs2,
        output wb_valid, wb_data, wb_tag, wb_err
    );

    modport slave (
        output req_valid, req_op, req_rs1, req_rs2, req_tag,
        output fu_accepted, fu_done, fu_rd, wb_ready,
        input  req_ready, fu_order, fu_rs1, fu_rs2,
        input  wb_valid, wb_data, wb_tag, wb_err
    );

endinterface

// File: rtl/fpu_issue_ctrl_result_mux.sv
// Selects the result lane of the unit addressed by the latched op code.
module fpu_result_mux
    import fpu_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int OP_W    = 2
) (
    input  logic [FU_DATA_W*N_UNITS-1:0] rd_i,
    input  logic [OP_W-1:0]              sel_i,
    output logic [FU_DATA_W-1:0]         data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (sel_i == OP_W'(k)) data_o = rd_i[FU_DATA_W*k +: FU_DATA_W];
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Core-side FPU initiator: issues one op, waits for the unit's done pulse (or a
// timeout) and holds the result for writeback until it is consumed.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int TAG_W   = 5,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rstn,
    fpu_issue_ctrl_if.master  bus_io
);

    localparam int OP_W = op_w(N_UNITS);
    // Count value one short of all-ones: the increment out of it is the timeout.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    fpu_state_e         state_q, state_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [31:0]        rs1_q, rs1_d;
    logic [31:0]        rs2_q, rs2_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               wb_err_q, wb_err_d;

    logic               req_ready;
    logic               req_legal;
    logic               acc_sel;
    logic               done_sel;
    logic [31:0]        res_sel;
    logic [N_UNITS-1:0] order;

    fpu_result_mux #(
        .N_UNITS (N_UNITS),
        .OP_W    (OP_W)
    ) u_result_mux (
        .rd_i   (bus_io.fu_rd),
        .sel_i  (op_q),
        .data_o (res_sel)
    );

    assign req_legal = (int'(bus_io.req_op) < N_UNITS);
    assign acc_sel   = bus_io.fu_accepted[op_q];
    assign done_sel  = bus_io.fu_done[op_q];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        wb_data_d = wb_data_q;
        wb_err_d  = wb_err_q;
        req_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_ISSUE: begin
                if (acc_sel) begin
                    if (done_sel) begin
                        wb_data_d = res_sel;
                        wb_err_d  = 1'b0;
                        state_d   = ST_WB;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A done arriving on the last counted cycle still wins over the timeout.
                if (done_sel) begin
                    wb_data_d = res_sel;
                    wb_err_d  = 1'b0;
                    state_d   = ST_WB;
                end else if (cnt_q == TO_LAST) begin
                    wb_data_d = '0;
                    wb_err_d  = 1'b1;
                    state_d   = ST_WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                if (bus_io.wb_ready) begin
                    req_ready = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (req_ready && bus_io.req_valid) begin
            op_d  = bus_io.req_op;
            rs1_d = bus_io.req_rs1;
            rs2_d = bus_io.req_rs2;
            tag_d = bus_io.req_tag;
            if (req_legal) begin
                state_d = ST_ISSUE;
            end else begin
                wb_data_d = '0;
                wb_err_d  = 1'b1;
                state_d   = ST_WB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    // Order is a pure decode of ISSUE, so it drops in the cycle after accept.
    always_comb begin
        order = '0;
        if (state_q == ST_ISSUE) order[op_q] = 1'b1;
    end

    assign bus_io.req_ready = req_ready;
    assign bus_io.fu_order  = order;
    assign bus_io.fu_rs1    = rs1_q;
    assign bus_io.fu_rs2    = rs2_q;
    assign bus_io.wb_valid  = (state_q == ST_WB);
    assign bus_io.wb_data   = wb_data_q;
    assign bus_io.wb_tag    = tag_q;
    assign bus_io.wb_err    = wb_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed and randomized bench for fpu_issue_ctrl with a transaction-level model.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int NU      = 3;
    localparam int TW      = 5;
    localparam int TOW     = 8;
    localparam int OPW     = op_w(NU);
    localparam int TIMEOUT = (1 << TOW) - 1;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl_if #(.N_UNITS(NU), .TAG_W(TW)) bus ();

    fpu_issue_ctrl #(.N_UNITS(NU), .TAG_W(TW), .TO_W(TOW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Random activity on every unit except sel (sel < 0: all units).
    task automatic noise(input int sel);
        logic [NU-1:0] m;
        m = '1;
        if (sel >= 0 && sel < NU) m[sel] = 1'b0;
        bus.fu_done     = NU'($urandom) & m;
        bus.fu_accepted = NU'($urandom) & m;
        for (int k = 0; k < NU; k++) bus.fu_rd[32*k +: 32] = $urandom;
    endtask

    // Transaction outcome: error for an illegal op or a unit silent past the timeout.
    function automatic void predict(input int op, input int lat, input logic [31:0] rd,
                                    output logic [31:0] d, output logic e);
        e = (op >= NU) || (lat < 0) || (lat > TIMEOUT);
        d = e ? 32'h0 : rd;
    endfunction

    task automatic check_reset(input string t);
        #1;
        chk({t, "_order"}, bus.fu_order, 0);
        chk({t, "_wb_valid"}, bus.wb_valid, 0);
        chk({t, "_wb_err"}, bus.wb_err, 0);
        chk({t, "_wb_data"}, bus.wb_data, 0);
        chk({t, "_wb_tag"}, bus.wb_tag, 0);
        chk({t, "_rs1"}, bus.fu_rs1, 0);
        chk({t, "_rs2"}, bus.fu_rs2, 0);
        chk({t, "_req_ready"}, bus.req_ready, 1);
    endtask

    task automatic issue_req(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                             input int tag);
        bus.req_valid = 1'b1;
        bus.req_op    = OPW'(op);
        bus.req_rs1   = rs1;
        bus.req_rs2   = rs2;
        bus.req_tag   = TW'(tag);
        #1;
        chk("req_ready", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        bus.wb_ready  = 1'b0;
        bus.req_op    = OPW'($urandom);
        bus.req_rs1   = $urandom;
        bus.req_rs2   = $urandom;
        bus.req_tag   = TW'($urandom);
    endtask

    // Plays the selected unit: busy cycles before accept, then done lat cycles after
    // accept (0: same cycle, <0: never).
    task automatic unit_phase(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                              input int busy, input int lat, input logic [31:0] rd);
        if (op >= NU) return;
        for (int i = 0; i <= busy; i++) begin
            noise(op);
            if (i == busy) begin
                bus.fu_accepted[op] = 1'b1;
                if (lat == 0) begin
                    bus.fu_done[op]        = 1'b1;
                    bus.fu_rd[32*op +: 32] = rd;
                end
            end
            #1;
            chk("issue_order", bus.fu_order, 64'(1) << op);
            chk("issue_rs1", bus.fu_rs1, rs1);
            chk("issue_rs2", bus.fu_rs2, rs2);
            chk("issue_stall", bus.req_ready, 0);
            chk("issue_wb_valid", bus.wb_valid, 0);
            step();
        end
        if (lat == 0) return;
        for (int w = 1; w <= TIMEOUT; w++) begin
            noise(op);
            if (w == lat) begin
                bus.fu_done[op]        = 1'b1;
                bus.fu_rd[32*op +: 32] = rd;
            end
            #1;
            chk("wait_order", bus.fu_order, 0);
            chk("wait_rs1", bus.fu_rs1, rs1);
            chk("wait_rs2", bus.fu_rs2, rs2);
            chk("wait_stall", bus.req_ready, 0);
            chk("wait_wb_valid", bus.wb_valid, 0);
            step();
            if (w == lat) break;
        end
    endtask

    // Holds wb_ready low for stall cycles, then raises it; leaves the bench in that cycle.
    task automatic wb_phase(input int tag, input logic [31:0] d, input logic e, input int stall);
        for (int s = 0; s <= stall; s++) begin
            noise(-1);
            bus.wb_ready = (s == stall);
            #1;
            chk("wb_valid", bus.wb_valid, 1);
            chk("wb_data", bus.wb_data, d);
            chk("wb_tag", bus.wb_tag, tag);
            chk("wb_err", bus.wb_err, e);
            chk("wb_order", bus.fu_order, 0);
            chk("wb_req_ready", bus.req_ready, (s == stall) ? 1 : 0);
            if (s < stall) step();
        end
    endtask

    task automatic finish_idle();
        step();
        bus.wb_ready = 1'b0;
        noise(-1);
        #1;
        chk("idle_wb_valid", bus.wb_valid, 0);
        chk("idle_req_ready", bus.req_ready, 1);
        chk("idle_order", bus.fu_order, 0);
    endtask

    task automatic do_op(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input int tag, input int busy, input int lat,
                         input logic [31:0] rd, input int stall);
        logic [31:0] d;
        logic        e;
        issue_req(op, rs1, rs2, tag);
        unit_phase(op, rs1, rs2, busy, lat, rd);
        predict(op, lat, rd, d, e);
        wb_phase(tag, d, e, stall);
        finish_idle();
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        bit          in_wb;

        rstn            = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_tag     = '0;
        bus.fu_accepted = '0;
        bus.fu_done     = '0;
        bus.fu_rd       = '0;
        bus.wb_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("rst");
        rstn = 1'b1;

        // Divide on an idle unit, done 20 cycles after accept.
        do_op(int'(FOP_DIV), 32'h40C00000, 32'h40000000, 3, 0, 20, 32'h40400000, 0);
        // Busy multiplier: accept withheld for 5 cycles.
        do_op(int'(FOP_MUL), 32'h40400000, 32'hC0800000, 7, 5, 4, 32'hC1400000, 0);
        // Zero-latency add.
        do_op(int'(FOP_ADD), 32'h3F000000, 32'h3F000000, 9, 0, 0, 32'h3F800000, 0);

        // Writeback back-pressure with a queued add, then back-to-back issue.
        issue_req(int'(FOP_DIV), 32'h41200000, 32'h40A00000, 12);
        unit_phase(int'(FOP_DIV), 32'h41200000, 32'h40A00000, 0, 6, 32'h40000000);
        predict(int'(FOP_DIV), 6, 32'h40000000, d, e);
        bus.req_valid = 1'b1;
        bus.req_op    = OPW'(int'(FOP_ADD));
        bus.req_rs1   = 32'h3F800000;
        bus.req_rs2   = 32'h40000000;
        bus.req_tag   = TW'(13);
        wb_phase(12, d, e, 4);
        issue_req(int'(FOP_ADD), 32'h3F800000, 32'h40000000, 13);
        unit_phase(int'(FOP_ADD), 32'h3F800000, 32'h40000000, 0, 2, 32'h40400000);
        predict(int'(FOP_ADD), 2, 32'h40400000, d, e);
        wb_phase(13, d, e, 0);
        finish_idle();

        // Unit never answers: timeout, with late and foreign done pulses ignored.
        do_op(int'(FOP_MUL), 32'h12345678, 32'h9ABCDEF0, 21, 1, -1, 32'hDEADBEEF, 2);
        // Op code beyond the attached units.
        do_op(3, 32'h11111111, 32'h22222222, 30, 0, 5, 32'hCAFEF00D, 1);

        // Reset during WAIT abandons the op; the next one completes normally.
        issue_req(int'(FOP_MUL), 32'hAAAA5555, 32'h5555AAAA, 17);
        noise(int'(FOP_MUL));
        bus.fu_accepted[int'(FOP_MUL)] = 1'b1;
        #1;
        chk("rstw_order", bus.fu_order, 64'(1) << int'(FOP_MUL));
        step();
        for (int i = 0; i < 3; i++) begin
            noise(int'(FOP_MUL));
            step();
        end
        rstn            = 1'b0;
        bus.fu_accepted = '0;
        bus.fu_done     = '0;
        step();
        check_reset("rst_wait");
        rstn = 1'b1;
        do_op(int'(FOP_DIV), 32'h40800000, 32'h40000000, 5, 1, 3, 32'h40000000, 1);

        // Randomized operations, optionally back-to-back from writeback.
        in_wb = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int          op, busy, lat, stall, tag;
            logic [31:0] a, b, rd;
            op    = $urandom_range(0, 3);
            busy  = $urandom_range(0, 3);
            lat   = $urandom_range(0, 12);
            stall = $urandom_range(0, 3);
            tag   = $urandom_range(0, 31);
            a     = $urandom;
            b     = $urandom;
            rd    = $urandom;
            issue_req(op, a, b, tag);
            unit_phase(op, a, b, busy, lat, rd);
            predict(op, lat, rd, d, e);
            wb_phase(tag, d, e, stall);
            in_wb = ($urandom_range(0, 1) == 1);
            if (!in_wb) finish_idle();
        end
        if (in_wb) finish_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
